// File: rtl/enc_parity_sched.sv
// Round-robin scheduler that sequences the shared 8-bit and 16-bit Hamming parity
// units for two requesters and hands back assembled codewords on a valid/ready port.
module enc_parity_sched #(
  parameter bit RR_INIT = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_mode,
  input  logic [10:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_mode,
  input  logic [10:0]      req1_data,
  output logic             req1_ready,
  output logic             p8_en,
  output logic [3:0]       p8_data,
  input  logic [3:0]       p8_parity,
  output logic             p16_en,
  output logic [6:0]       p16_data,
  output logic [3:0]       p16_p8,
  input  logic [4:0]       p16_parity,
  output logic             cw_valid,
  input  logic             cw_ready,
  output logic [15:0]      cw_data,
  output logic             cw_mode,
  output logic             cw_src,
  output logic [CNT_W-1:0] cnt8,
  output logic [CNT_W-1:0] cnt16,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_P8 = 2'd1, S_P16 = 2'd2, S_OUT = 2'd3} state_t;

  state_t           state_q, state_d;
  logic             prio_q;
  logic [10:0]      data_q;
  logic             mode_q;
  logic             src_q;
  logic [3:0]       p8_q;
  logic [4:0]       p16_q;
  logic [CNT_W-1:0] cnt8_q, cnt16_q;

  logic grant_any;
  logic grant_idx;
  logic cw_fire;

  // Handshakes: a requester word moves when reqN_valid && reqN_ready (IDLE only);
  // a codeword moves when cw_valid && cw_ready, and is held unchanged until then.
  always_comb begin
    grant_any  = (state_q == S_IDLE) && (req0_valid || req1_valid);
    grant_idx  = (req0_valid && req1_valid) ? prio_q : req1_valid;
    req0_ready = grant_any && !grant_idx;
    req1_ready = grant_any && grant_idx;
    cw_fire    = (state_q == S_OUT) && cw_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_any) state_d = S_P8;
      S_P8:    state_d = mode_q ? S_P16 : S_OUT;
      S_P16:   state_d = S_OUT;
      S_OUT:   if (cw_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Unit and codeword outputs decode straight from flops, so they are zero outside their state.
  always_comb begin
    p8_en    = 1'b0;
    p8_data  = 4'h0;
    p16_en   = 1'b0;
    p16_data = 7'h00;
    p16_p8   = 4'h0;
    cw_valid = 1'b0;
    cw_data  = 16'h0000;
    cw_mode  = 1'b0;
    cw_src   = 1'b0;
    case (state_q)
      S_P8: begin
        p8_en   = 1'b1;
        p8_data = data_q[3:0];
      end
      S_P16: begin
        p16_en   = 1'b1;
        p16_data = data_q[10:4];
        p16_p8   = p8_q;
      end
      S_OUT: begin
        cw_valid = 1'b1;
        cw_data  = mode_q ? {data_q, p16_q} : {8'h00, data_q[3:0], p8_q};
        cw_mode  = mode_q;
        cw_src   = src_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio_q  <= RR_INIT;
      data_q  <= '0;
      mode_q  <= 1'b0;
      src_q   <= 1'b0;
      p8_q    <= '0;
      p16_q   <= '0;
      cnt8_q  <= '0;
      cnt16_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_any) begin
        data_q <= grant_idx ? req1_data : req0_data;
        mode_q <= grant_idx ? req1_mode : req0_mode;
        src_q  <= grant_idx;
        prio_q <= ~grant_idx;
      end
      if (state_q == S_P8)  p8_q  <= p8_parity;
      if (state_q == S_P16) p16_q <= p16_parity;
      if (cw_fire) begin
        if (!mode_q && cnt8_q != '1)  cnt8_q  <= cnt8_q + CNT_W'(1);
        if (mode_q && cnt16_q != '1)  cnt16_q <= cnt16_q + CNT_W'(1);
      end
    end
  end

  assign cnt8      = cnt8_q;
  assign cnt16     = cnt16_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_enc_parity_sched.sv
// Directed bench for enc_parity_sched: reset, both modes, contention, back-pressure,
// mid-operation reset and counter saturation on a narrow-counter instance.
module tb_enc_parity_sched;

  logic        clk, rst, rst_s;
  logic        req0_valid, req0_mode, req1_valid, req1_mode;
  logic [10:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        p8_en, p16_en;
  logic [3:0]  p8_data, p8_parity, p16_p8;
  logic [6:0]  p16_data;
  logic [4:0]  p16_parity;
  logic        cw_valid, cw_ready, cw_mode, cw_src;
  logic [15:0] cw_data;
  logic [15:0] cnt8, cnt16;
  logic [1:0]  dbg_state;

  logic        s_req0_ready, s_req1_ready, s_p8_en, s_p16_en;
  logic [3:0]  s_p8_data, s_p16_p8;
  logic [6:0]  s_p16_data;
  logic        s_cw_valid, s_cw_mode, s_cw_src;
  logic [15:0] s_cw_data;
  logic [1:0]  s_cnt8, s_cnt16;
  logic [1:0]  s_dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  enc_parity_sched #(.RR_INIT(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_data(req1_data), .req1_ready(req1_ready),
    .p8_en(p8_en), .p8_data(p8_data), .p8_parity(p8_parity),
    .p16_en(p16_en), .p16_data(p16_data), .p16_p8(p16_p8), .p16_parity(p16_parity),
    .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_mode(cw_mode), .cw_src(cw_src),
    .cnt8(cnt8), .cnt16(cnt16), .dbg_state(dbg_state)
  );

  enc_parity_sched #(.RR_INIT(1'b0), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst_s),
    .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .p8_en(s_p8_en), .p8_data(s_p8_data), .p8_parity(p8_parity),
    .p16_en(s_p16_en), .p16_data(s_p16_data), .p16_p8(s_p16_p8), .p16_parity(p16_parity),
    .cw_valid(s_cw_valid), .cw_ready(cw_ready), .cw_data(s_cw_data), .cw_mode(s_cw_mode), .cw_src(s_cw_src),
    .cnt8(s_cnt8), .cnt16(s_cnt16), .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rst_s = 1'b0;
    req0_valid = 1'b0; req0_mode = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_mode = 1'b0; req1_data = '0;
    p8_parity = '0; p16_parity = '0; cw_ready = 1'b1;
    #2 rst = 1'b1; rst_s = 1'b1;
    #1;
    n_cmp++; if (cw_valid !== 1'b0 || cw_data !== 16'h0 || cw_mode !== 1'b0 || cw_src !== 1'b0) begin
      n_fail++; $display("FAIL reset_cw got v=%b d=%h m=%b s=%b want all 0", cw_valid, cw_data, cw_mode, cw_src); end
    n_cmp++; if (p8_en !== 1'b0 || p8_data !== 4'h0 || p16_en !== 1'b0 || p16_data !== 7'h0 || p16_p8 !== 4'h0) begin
      n_fail++; $display("FAIL reset_units got %b %h %b %h %h want all 0", p8_en, p8_data, p16_en, p16_data, p16_p8); end
    n_cmp++; if (cnt8 !== 16'h0 || cnt16 !== 16'h0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_cnt got cnt8=%0d cnt16=%0d st=%0d want 0", cnt8, cnt16, dbg_state); end
    n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready); end
    #9 rst = 1'b0;
    step;
    // both valid with prio=RR_INIT=0: requester 0 must win; valid withdrawn before the edge
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_prio got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step;
  endtask

  task automatic test_mode0;
    req0_valid = 1'b1; req0_mode = 1'b0; req0_data = 11'h00A; p8_parity = 4'h5;
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL m0_grant got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
    step;
    req0_valid = 1'b0;
    #1;
    n_cmp++; if (p8_en !== 1'b1 || p8_data !== 4'hA || p16_en !== 1'b0 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL m0_p8 got en=%b d=%h p16en=%b r0=%b want 1 a 0 0", p8_en, p8_data, p16_en, req0_ready); end
    step;
    n_cmp++; if (cw_valid !== 1'b1 || cw_data !== 16'h00A5 || cw_src !== 1'b0 || cw_mode !== 1'b0) begin
      n_fail++; $display("FAIL m0_cw got v=%b d=%h s=%b m=%b want 1 00a5 0 0", cw_valid, cw_data, cw_src, cw_mode); end
    n_cmp++; if (cnt8 !== 16'd0) begin n_fail++; $display("FAIL m0_cnt_pre got %0d want 0", cnt8); end
    step;
    n_cmp++; if (cw_valid !== 1'b0 || cw_data !== 16'h0 || cnt8 !== 16'd1 || cnt16 !== 16'd0) begin
      n_fail++; $display("FAIL m0_done got v=%b d=%h cnt8=%0d cnt16=%0d want 0 0 1 0", cw_valid, cw_data, cnt8, cnt16); end
  endtask

  task automatic test_mode1;
    req1_valid = 1'b1; req1_mode = 1'b1; req1_data = 11'h5A3; p8_parity = 4'h3; p16_parity = 5'h1B;
    #1;
    n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL m1_grant got r1=%b r0=%b want 1 0", req1_ready, req0_ready); end
    step;
    req1_valid = 1'b0;
    n_cmp++; if (p8_en !== 1'b1 || p8_data !== 4'h3) begin
      n_fail++; $display("FAIL m1_p8 got en=%b d=%h want 1 3", p8_en, p8_data); end
    step;
    n_cmp++; if (p16_en !== 1'b1 || p16_data !== 7'h5A || p16_p8 !== 4'h3 || p8_en !== 1'b0 || cw_valid !== 1'b0) begin
      n_fail++; $display("FAIL m1_p16 got en=%b d=%h p8=%h p8en=%b cwv=%b want 1 5a 3 0 0", p16_en, p16_data, p16_p8, p8_en, cw_valid); end
    step;
    n_cmp++; if (cw_valid !== 1'b1 || cw_data !== 16'hB47B || cw_src !== 1'b1 || cw_mode !== 1'b1 || p16_en !== 1'b0) begin
      n_fail++; $display("FAIL m1_cw got v=%b d=%h s=%b m=%b want 1 b47b 1 1", cw_valid, cw_data, cw_src, cw_mode); end
    step;
    n_cmp++; if (cnt16 !== 16'd1 || cnt8 !== 16'd1 || cw_valid !== 1'b0) begin
      n_fail++; $display("FAIL m1_done got cnt16=%0d cnt8=%0d v=%b want 1 1 0", cnt16, cnt8, cw_valid); end
  endtask

  task automatic test_contention;
    int n0, n1, who;
    logic [10:0] d_exp;
    n0 = 0; n1 = 0;
    p8_parity = 4'h7;
    req0_valid = 1'b1; req0_mode = 1'b0; req0_data = 11'h000;
    req1_valid = 1'b1; req1_mode = 1'b0; req1_data = 11'h008;
    for (int k = 0; k < 8; k++) begin
      who = -1;
      for (int c = 0; c < 20 && who < 0; c++) begin
        #1;
        if (req0_ready) who = 0;
        else if (req1_ready) who = 1;
        else step;
      end
      n_cmp++; if (who != (k % 2)) begin
        n_fail++; $display("FAIL cont_grant%0d got %0d want %0d", k, who, k % 2); end
      if (who < 0) return;
      d_exp = (who == 1) ? req1_data : req0_data;
      step;
      if (who == 0) begin
        n0++;
        if (n0 == 4) req0_valid = 1'b0; else req0_data = 11'(n0);
      end else begin
        n1++;
        if (n1 == 4) req1_valid = 1'b0; else req1_data = 11'(8 + n1);
      end
      step;
      n_cmp++; if (cw_valid !== 1'b1 || cw_src !== who[0] || cw_data !== {8'h00, d_exp[3:0], 4'h7}) begin
        n_fail++; $display("FAIL cont_cw%0d got v=%b s=%b d=%h want 1 %0d %h", k, cw_valid, cw_src, cw_data, who, {8'h00, d_exp[3:0], 4'h7}); end
      step;
    end
    n_cmp++; if (cnt8 !== 16'd9) begin n_fail++; $display("FAIL cont_cnt8 got %0d want 9", cnt8); end
  endtask

  task automatic test_back_pressure;
    int bad;
    cw_ready = 1'b0;
    req0_valid = 1'b1; req0_mode = 1'b0; req0_data = 11'h00C; p8_parity = 4'h9;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_grant got %b want 1", req0_ready); end
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_mode = 1'b0; req1_data = 11'h005;
    step;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cw_valid !== 1'b1 || cw_data !== 16'h00C9 || cw_src !== 1'b0 || req1_ready !== 1'b0 || dbg_state !== 2'd3) bad++;
      p8_parity = 4'hF;
      step;
    end
    n_cmp++; if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold got %0d bad cycles (v=%b d=%h s=%b r1=%b) want 0", bad, cw_valid, cw_data, cw_src, req1_ready); end
    n_cmp++; if (cnt8 !== 16'd9) begin n_fail++; $display("FAIL bp_cnt_hold got %0d want 9", cnt8); end
    req1_valid = 1'b0;
    cw_ready = 1'b1;
    step;
    n_cmp++; if (cw_valid !== 1'b0 || cnt8 !== 16'd10 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL bp_release got v=%b cnt8=%0d st=%0d want 0 10 0", cw_valid, cnt8, dbg_state); end
  endtask

  task automatic test_reset_midop;
    int seen;
    req1_valid = 1'b1; req1_mode = 1'b1; req1_data = 11'h7FF; p8_parity = 4'h2; p16_parity = 5'h05;
    step;
    req1_valid = 1'b0;
    step;
    n_cmp++; if (p16_en !== 1'b1) begin n_fail++; $display("FAIL rmid_in_p16 got %b want 1", p16_en); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cw_valid !== 1'b0 || p16_en !== 1'b0 || cnt8 !== 16'd0 || cnt16 !== 16'd0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rmid_async got v=%b p16en=%b cnt8=%0d cnt16=%0d st=%0d want 0", cw_valid, p16_en, cnt8, cnt16, dbg_state); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (cw_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_cw got %0d cycles valid want 0", seen); end
    req0_valid = 1'b1; req0_mode = 1'b0; req0_data = 11'h003; p8_parity = 4'h1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant got %b want 1", req0_ready); end
    step;
    req0_valid = 1'b0;
    step;
    n_cmp++; if (cw_valid !== 1'b1 || cw_data !== 16'h0031 || cw_src !== 1'b0) begin
      n_fail++; $display("FAIL rmid_cw got v=%b d=%h s=%b want 1 0031 0", cw_valid, cw_data, cw_src); end
    step;
    n_cmp++; if (cnt8 !== 16'd1 || cnt16 !== 16'd0) begin
      n_fail++; $display("FAIL rmid_cnt got cnt8=%0d cnt16=%0d want 1 0", cnt8, cnt16); end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_s;
    rst = 1'b1; rst_s = 1'b1;
    #2 rst = 1'b0; rst_s = 1'b0;
    step;
    p8_parity = 4'h4;
    for (int n = 1; n <= 5; n++) begin
      req0_valid = 1'b1; req0_mode = 1'b0; req0_data = 11'(n);
      #1;
      n_cmp++; if (s_req0_ready !== 1'b1) begin n_fail++; $display("FAIL sat_grant%0d got %b want 1", n, s_req0_ready); end
      step;
      req0_valid = 1'b0;
      step;
      step;
      exp_s = (n > 3) ? 2'd3 : 2'(n);
      n_cmp++; if (s_cnt8 !== exp_s || cnt8 !== 16'(n) || s_cnt16 !== 2'd0) begin
        n_fail++; $display("FAIL sat_cnt%0d got s_cnt8=%0d cnt8=%0d s_cnt16=%0d want %0d %0d 0", n, s_cnt8, cnt8, s_cnt16, exp_s, n); end
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode1;
    test_contention;
    test_back_pressure;
    test_reset_midop;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
